// File: rtl/dds_multi_pkg.sv
// Shared encodings for the multi-channel DDS: waveform modes, config register
// codes and sequencer states.
package dds_multi_pkg;

   typedef enum logic [1:0] {
      MODE_SINE   = 2'd0,
      MODE_SQUARE = 2'd1,
      MODE_TRI    = 2'd2,
      MODE_SAW    = 2'd3
   } dds_mode_e;

   typedef enum logic [1:0] {
      REG_FREQ  = 2'd0,
      REG_PHASE = 2'd1,
      REG_AMP   = 2'd2,
      REG_MODE  = 2'd3
   } dds_reg_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } dds_state_e;

   localparam int CFG_DW = 32;

   // A single channel still needs a one-bit channel select.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dds_multi_if.sv
// Control/config/output bundle between the config front end and dds_multi.
interface dds_multi_if #(
   parameter int CHANNELS = 2,
   parameter int LUT_AW   = 8,
   parameter int OUT_W    = 8
) ();
   localparam int CH_W = dds_multi_pkg::ch_width(CHANNELS);

   // sample_en is a one-cycle strobe with no back-pressure: it is accepted only
   // when busy=0 in the same cycle, otherwise dropped and recorded in overrun.
   // cfg_we and lut_we are single-cycle write strobes; lut_we is ignored while
   // busy=0 does not hold. wave_valid pulses for one cycle when wave changes.
   logic                      sample_en;
   logic                      phase_sync;
   logic                      cfg_we;
   logic [CH_W-1:0]           cfg_ch;
   logic [1:0]                cfg_reg;
   logic [31:0]               cfg_data;
   logic                      lut_we;
   logic [LUT_AW-1:0]         lut_addr;
   logic [OUT_W-2:0]          lut_data;
   logic [CHANNELS*OUT_W-1:0] wave;
   logic                      wave_valid;
   logic                      busy;
   logic                      overrun;
   dds_multi_pkg::dds_state_e dbg_state;

   modport master (
      output sample_en, phase_sync, cfg_we, cfg_ch, cfg_reg, cfg_data,
             lut_we, lut_addr, lut_data,
      input  wave, wave_valid, busy, overrun, dbg_state
   );

   modport slave (
      input  sample_en, phase_sync, cfg_we, cfg_ch, cfg_reg, cfg_data,
             lut_we, lut_addr, lut_data,
      output wave, wave_valid, busy, overrun, dbg_state
   );

endinterface

// File: rtl/dds_multi_lut.sv
// Single-port quarter-wave magnitude RAM, read-first, one-cycle read latency.
// Contents are not reset; they are loaded through the write port.
module dds_multi_lut #(
   parameter int AW = 8,
   parameter int DW = 7
) (
   input  logic          src_clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge src_clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dds_multi.sv
// Multi-channel DDS: per-channel phase accumulators and config banks sharing
// one quarter-wave LUT through a 3-stage time-multiplexed pipeline.
module dds_multi
   import dds_multi_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int ACC_W    = 32,
   parameter int LUT_AW   = 8,
   parameter int OUT_W    = 8,
   parameter int AMP_W    = 8
) (
   input logic        src_clk,
   input logic        rst,
   dds_multi_if.slave bus
);

   localparam int P_W  = LUT_AW + 2;
   localparam int CH_W = ch_width(CHANNELS);
   localparam int MW   = OUT_W + AMP_W;
   localparam int SW   = OUT_W + AMP_W + 2;
   localparam logic [OUT_W-1:0] MID    = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-2:0] MID_M1 = {(OUT_W-1){1'b1}};

   logic [ACC_W-1:0] pend_freq [CHANNELS];
   logic [P_W-1:0]   pend_off  [CHANNELS];
   logic [AMP_W-1:0] pend_amp  [CHANNELS];
   logic [1:0]       pend_mode [CHANNELS];
   logic [ACC_W-1:0] acc       [CHANNELS];
   logic [ACC_W-1:0] acc_base  [CHANNELS];
   logic [P_W-1:0]   phase     [CHANNELS];
   logic [AMP_W-1:0] act_amp   [CHANNELS];
   logic [1:0]       act_mode  [CHANNELS];
   logic [OUT_W-1:0] stage_q   [CHANNELS];

   dds_state_e state, state_nxt;
   logic [CH_W-1:0] cnt, cnt_nxt;
   logic busy, accept, sync_pend, sync_now, overrun_r, wave_load, wave_valid_r;
   logic [CHANNELS*OUT_W-1:0] wave_r;

   logic [P_W-1:0]    cur_p;
   logic [LUT_AW-1:0] cur_idx, ram_addr;
   logic              ram_we;
   logic [OUT_W-2:0]  ram_rdata;

   logic              rd_vld;
   logic [CH_W-1:0]   rd_ch;
   logic [LUT_AW-1:0] rd_idx;
   logic [OUT_W-1:0]  rd_saw;
   logic [AMP_W-1:0]  rd_amp;
   logic [1:0]        rd_mode;

   logic [AMP_W:0]          amp1;
   logic [OUT_W-2:0]        tri_mag, mag;
   logic [OUT_W-1:0]        scaled, sq, saw_s, out_val;
   logic signed [OUT_W-1:0] saw_sv;

   assign busy     = (state != ST_IDLE) || wave_valid_r;
   assign accept   = bus.sample_en && !busy;
   assign sync_now = sync_pend || bus.phase_sync;

   assign bus.busy       = busy;
   assign bus.overrun    = overrun_r;
   assign bus.wave       = wave_r;
   assign bus.wave_valid = wave_valid_r;
   assign bus.dbg_state  = state;

   // Pending bank: written any time, copied to the active bank on accept.
   always_ff @(posedge src_clk) begin
      if (rst) begin
         for (int k = 0; k < CHANNELS; k++) begin
            pend_freq[k] <= '0;
            pend_off[k]  <= '0;
            pend_amp[k]  <= '1;
            pend_mode[k] <= '0;
         end
      end else if (bus.cfg_we && (int'(bus.cfg_ch) < CHANNELS)) begin
         case (dds_reg_e'(bus.cfg_reg))
            REG_FREQ:  pend_freq[bus.cfg_ch] <= ACC_W'(bus.cfg_data);
            REG_PHASE: pend_off[bus.cfg_ch]  <= P_W'(bus.cfg_data);
            REG_AMP:   pend_amp[bus.cfg_ch]  <= AMP_W'(bus.cfg_data);
            default:   pend_mode[bus.cfg_ch] <= bus.cfg_data[1:0];
         endcase
      end
   end

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) acc_base[k] = sync_now ? '0 : acc[k];
   end

   // Phase is taken from the pre-increment accumulator for every channel at once.
   always_ff @(posedge src_clk) begin
      if (rst) begin
         for (int k = 0; k < CHANNELS; k++) begin
            acc[k]      <= '0;
            phase[k]    <= '0;
            act_amp[k]  <= '1;
            act_mode[k] <= '0;
         end
      end else if (accept) begin
         for (int k = 0; k < CHANNELS; k++) begin
            phase[k]    <= acc_base[k][ACC_W-1 -: P_W] + pend_off[k];
            acc[k]      <= acc_base[k] + pend_freq[k];
            act_amp[k]  <= pend_amp[k];
            act_mode[k] <= pend_mode[k];
         end
      end
   end

   always_ff @(posedge src_clk) begin
      if (rst) begin
         sync_pend <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         if (accept)              sync_pend <= 1'b0;
         else if (bus.phase_sync) sync_pend <= 1'b1;
         if (bus.phase_sync)                overrun_r <= 1'b0;
         else if (bus.sample_en && busy)    overrun_r <= 1'b1;
      end
   end

   always_ff @(posedge src_clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wave_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            if (cnt == CH_W'(CHANNELS - 1)) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_FLUSH: begin
            if (cnt == CH_W'(1)) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               wave_load = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Address stage: odd quadrants read the table backwards.
   always_comb begin
      cur_p   = phase[cnt];
      cur_idx = cur_p[P_W-2] ? ~cur_p[LUT_AW-1:0] : cur_p[LUT_AW-1:0];
   end

   assign ram_we   = bus.lut_we && !busy;
   assign ram_addr = ram_we ? bus.lut_addr : cur_idx;

   dds_multi_lut #(.AW(LUT_AW), .DW(OUT_W-1)) u_lut (
      .src_clk (src_clk),
      .we      (ram_we),
      .addr    (ram_addr),
      .wdata   (bus.lut_data),
      .rdata   (ram_rdata)
   );

   always_ff @(posedge src_clk) begin
      if (rst) rd_vld <= 1'b0;
      else     rd_vld <= (state == ST_RUN);
   end

   always_ff @(posedge src_clk) begin
      rd_ch   <= cnt;
      rd_idx  <= cur_idx;
      rd_saw  <= cur_p[P_W-1 -: OUT_W];
      rd_amp  <= act_amp[cnt];
      rd_mode <= act_mode[cnt];
   end

   // Scale/sign stage; rd_saw MSB is the phase MSB, i.e. the negative half-cycle.
   always_comb begin
      amp1    = {1'b0, rd_amp} + (AMP_W+1)'(1);
      tri_mag = (OUT_W-1)'({rd_idx, {(OUT_W-1){1'b0}}} >> LUT_AW);
      mag     = (dds_mode_e'(rd_mode) == MODE_TRI) ? tri_mag : ram_rdata;
      scaled  = OUT_W'(({{(AMP_W+1){1'b0}}, mag} * {{(OUT_W-1){1'b0}}, amp1}) >> AMP_W);
      sq      = OUT_W'(({{(AMP_W+1){1'b0}}, MID_M1} * {{(OUT_W-1){1'b0}}, amp1}) >> AMP_W);
      saw_sv  = {~rd_saw[OUT_W-1], rd_saw[OUT_W-2:0]};
      saw_s   = OUT_W'((SW'(saw_sv) * SW'($signed({1'b0, amp1}))) >>> AMP_W);
      out_val = MID;
      case (dds_mode_e'(rd_mode))
         MODE_SQUARE: out_val = rd_saw[OUT_W-1] ? MID - sq : MID + sq;
         MODE_SAW:    out_val = MID + saw_s;
         default:     out_val = rd_saw[OUT_W-1] ? MID - scaled : MID + scaled;
      endcase
   end

   always_ff @(posedge src_clk) begin
      if (rst) begin
         for (int k = 0; k < CHANNELS; k++) stage_q[k] <= MID;
      end else if (rd_vld) begin
         stage_q[rd_ch] <= out_val;
      end
   end

   always_ff @(posedge src_clk) begin
      if (rst) begin
         for (int k = 0; k < CHANNELS; k++) wave_r[k*OUT_W +: OUT_W] <= MID;
         wave_valid_r <= 1'b0;
      end else begin
         wave_valid_r <= wave_load;
         if (wave_load) begin
            for (int k = 0; k < CHANNELS; k++) wave_r[k*OUT_W +: OUT_W] <= stage_q[k];
         end
      end
   end

   logic unused_mw;
   assign unused_mw = (MW == 0);

endmodule

// File: tb/tb_dds_multi.sv
// Directed bench for dds_multi: reset, table of waveform vectors, then
// overrun, config-timing, LUT-write and mid-pipeline reset sequences.
module tb_dds_multi;
   import dds_multi_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dds_multi_if #(.CHANNELS(2), .LUT_AW(8), .OUT_W(8)) bus ();

   dds_multi #(
      .CHANNELS(2), .ACC_W(32), .LUT_AW(8), .OUT_W(8), .AMP_W(8)
   ) dut (
      .src_clk (clk),
      .rst     (rst),
      .bus     (bus)
   );

   typedef struct {
      bit          sync;
      logic [1:0]  mode0;
      logic [7:0]  amp0;
      logic [9:0]  off0;
      logic [1:0]  mode1;
      logic [7:0]  amp1;
      logic [9:0]  off1;
      logic [15:0] exp_wave;
   } vec_t;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic cfg_write(input int ch, input logic [1:0] r, input logic [31:0] d);
      bus.cfg_we = 1'b1; bus.cfg_ch = 1'(ch); bus.cfg_reg = r; bus.cfg_data = d;
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask

   task automatic set_chan(input int ch, input logic [31:0] f, input logic [9:0] off,
                           input logic [7:0] amp, input logic [1:0] mode);
      cfg_write(ch, REG_FREQ, f);
      cfg_write(ch, REG_PHASE, {22'd0, off});
      cfg_write(ch, REG_AMP, {24'd0, amp});
      cfg_write(ch, REG_MODE, {30'd0, mode});
   endtask

   task automatic lut_write(input int addr, input logic [6:0] d);
      bus.lut_we = 1'b1; bus.lut_addr = 8'(addr); bus.lut_data = d;
      @(negedge clk);
      bus.lut_we = 1'b0;
   endtask

   task automatic pulse_sync();
      bus.phase_sync = 1'b1;
      @(negedge clk);
      bus.phase_sync = 1'b0;
   endtask

   task automatic drive_wr(input bit wr_lut, input int wr_sel, input logic [1:0] wr_reg,
                           input logic [31:0] wr_data);
      if (wr_lut) begin
         bus.lut_we = 1'b1; bus.lut_addr = 8'(wr_sel); bus.lut_data = wr_data[6:0];
      end else begin
         bus.cfg_we = 1'b1; bus.cfg_ch = 1'(wr_sel); bus.cfg_reg = wr_reg; bus.cfg_data = wr_data;
      end
   endtask

   // One strobe; optional write driven wr_at cycles after the strobe cycle.
   task automatic run_sample(input int wr_at, input bit wr_lut, input int wr_sel,
                             input logic [1:0] wr_reg, input logic [31:0] wr_data,
                             output logic [15:0] w, output int lat,
                             output logic busy1, output logic busy_end);
      bus.sample_en = 1'b1;
      if (wr_at == 0) drive_wr(wr_lut, wr_sel, wr_reg, wr_data);
      @(negedge clk);
      bus.sample_en = 1'b0; bus.cfg_we = 1'b0; bus.lut_we = 1'b0;
      busy1 = bus.busy;
      lat = 1;
      while (!bus.wave_valid && lat < 20) begin
         if (lat == wr_at) drive_wr(wr_lut, wr_sel, wr_reg, wr_data);
         @(negedge clk);
         bus.cfg_we = 1'b0; bus.lut_we = 1'b0;
         lat++;
      end
      w = bus.wave;
      @(negedge clk);
      busy_end = bus.busy | bus.wave_valid;
   endtask

   task automatic sample(output logic [15:0] w);
      int lat;
      logic b1, be;
      run_sample(-1, 1'b0, 0, 2'd0, 32'd0, w, lat, b1, be);
      check("sample_latency", 32'(lat), 32'd5);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[11];
      logic [15:0] w;
      int lat, seen;
      logic b1, be;

      vecs[0]  = '{1'b1, MODE_SINE,   8'd255, 10'd0,   MODE_SINE,   8'd255, 10'd256,  16'hFF80};
      vecs[1]  = '{1'b0, MODE_SINE,   8'd255, 10'd0,   MODE_SINE,   8'd255, 10'd256,  16'h80FF};
      vecs[2]  = '{1'b0, MODE_SINE,   8'd255, 10'd0,   MODE_SINE,   8'd255, 10'd256,  16'h0180};
      vecs[3]  = '{1'b0, MODE_SINE,   8'd255, 10'd0,   MODE_SINE,   8'd255, 10'd256,  16'h8001};
      vecs[4]  = '{1'b0, MODE_SINE,   8'd255, 10'd0,   MODE_SINE,   8'd255, 10'd256,  16'hFF80};
      vecs[5]  = '{1'b1, MODE_SINE,   8'd127, 10'd256, MODE_SQUARE, 8'd255, 10'd0,    16'hFFBF};
      vecs[6]  = '{1'b1, MODE_SQUARE, 8'd255, 10'd512, MODE_SQUARE, 8'd127, 10'd0,    16'hBF01};
      vecs[7]  = '{1'b1, MODE_TRI,    8'd255, 10'd100, MODE_TRI,    8'd255, 10'd356,  16'hCDB2};
      vecs[8]  = '{1'b1, MODE_TRI,    8'd255, 10'd612, MODE_SINE,   8'd255, 10'd868,  16'h334E};
      vecs[9]  = '{1'b1, MODE_SAW,    8'd255, 10'd0,   MODE_SAW,    8'd255, 10'd1023, 16'hFF00};
      vecs[10] = '{1'b1, MODE_SAW,    8'd127, 10'd0,   MODE_SAW,    8'd127, 10'd1020, 16'hBF40};

      rst = 1'b1;
      bus.sample_en = 1'b0; bus.phase_sync = 1'b0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
      bus.cfg_reg = '0; bus.cfg_data = '0; bus.lut_we = 1'b0; bus.lut_addr = '0; bus.lut_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_wave", 32'(bus.wave), 32'h8080);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_overrun", 32'(bus.overrun), 32'd0);
      check("reset_wave_valid", 32'(bus.wave_valid), 32'd0);
      check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));

      for (int i = 0; i < 256; i++) lut_write(i, 7'(i >> 1));
      sample(w);
      check("first_sample", 32'(w), 32'h8080);

      for (int i = 0; i < 11; i++) begin
         set_chan(0, 32'h4000_0000, vecs[i].off0, vecs[i].amp0, vecs[i].mode0);
         set_chan(1, 32'h4000_0000, vecs[i].off1, vecs[i].amp1, vecs[i].mode1);
         if (vecs[i].sync) pulse_sync();
         run_sample(-1, 1'b0, 0, 2'd0, 32'd0, w, lat, b1, be);
         check($sformatf("vec%0d_wave", i), 32'(w), 32'(vecs[i].exp_wave));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
         check($sformatf("vec%0d_busy_start", i), 32'(b1), 32'd1);
         check($sformatf("vec%0d_busy_end", i), 32'(be), 32'd0);
      end

      // Back-to-back strobes: second one dropped, accumulators advance once.
      set_chan(0, 32'h4000_0000, 10'd0, 8'd255, MODE_SINE);
      set_chan(1, 32'h4000_0000, 10'd0, 8'd255, MODE_SINE);
      pulse_sync();
      bus.sample_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.sample_en = 1'b0;
      lat = 2;
      while (!bus.wave_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("overrun_wave", 32'(bus.wave), 32'h8080);
      check("overrun_set", 32'(bus.overrun), 32'd1);
      @(negedge clk);
      sample(w);
      check("overrun_single_advance", 32'(w), 32'hFFFF);
      check("overrun_sticky", 32'(bus.overrun), 32'd1);
      pulse_sync();
      check("overrun_cleared", 32'(bus.overrun), 32'd0);

      // Config writes during busy and coincident with a strobe apply next sample.
      set_chan(0, 32'h4000_0000, 10'd0, 8'd255, MODE_SINE);
      pulse_sync();
      exp_q.push_back(16'h0080); exp_q.push_back(16'h00FF);
      exp_q.push_back(16'h0080); exp_q.push_back(16'h0041);
      run_sample(-1, 1'b0, 0, 2'd0, 32'd0, w, lat, b1, be);
      check("cfg_a", 32'(w[7:0]), 32'(exp_q.pop_front()));
      run_sample(2, 1'b0, 0, REG_FREQ, 32'h2000_0000, w, lat, b1, be);
      check("cfg_b_busy_write", 32'(w[7:0]), 32'(exp_q.pop_front()));
      run_sample(0, 1'b0, 0, REG_PHASE, 32'd256, w, lat, b1, be);
      check("cfg_c_same_cycle", 32'(w[7:0]), 32'(exp_q.pop_front()));
      run_sample(-1, 1'b0, 0, 2'd0, 32'd0, w, lat, b1, be);
      check("cfg_d_applied", 32'(w[7:0]), 32'(exp_q.pop_front()));

      // LUT write while busy must not land; an idle write must.
      set_chan(0, 32'd0, 10'd256, 8'd255, MODE_SINE);
      pulse_sync();
      run_sample(2, 1'b1, 255, 2'd0, 32'd0, w, lat, b1, be);
      check("lut_busy_sample", 32'(w[7:0]), 32'hFF);
      sample(w);
      check("lut_busy_ignored", 32'(w[7:0]), 32'hFF);
      lut_write(255, 7'd0);
      sample(w);
      check("lut_idle_write", 32'(w[7:0]), 32'h80);
      lut_write(255, 7'd127);

      // Reset two cycles into a sample (overrun set first so its clear is visible).
      bus.sample_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.sample_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         if (bus.wave_valid) seen++;
         @(negedge clk);
      end
      check("rst_no_wave_valid", 32'(seen), 32'd0);
      check("rst_wave", 32'(bus.wave), 32'h8080);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      sample(w);
      check("rst_config_defaults", 32'(w), 32'h8080);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
